// File: rtl/text_ram_arbiter.sv
// ============================================================================
//  Module      : text_ram_arbiter
//  Description : Two-port arbiter in front of a single-port text RAM. The
//                renderer gets priority with an anti-starvation counter for
//                the editor; the editor can lock the RAM for read-modify-
//                write, and a long lock is periodically broken so the
//                renderer still gets one slot per lock window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TEXT_RAM_LINE_WIDTH
`define TEXT_RAM_LINE_WIDTH 32
`endif

module text_ram_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned LINE_W     = `TEXT_RAM_LINE_WIDTH,
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [3:0]  STARVE_MAX = 4'd15,
    parameter logic [3:0]  LOCK_MAX   = 4'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    // renderer port (read only)
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic              r_valid,
    output logic [LINE_W-1:0] r_data,
    // editor port
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [LINE_W-1:0] e_wdata,
    input  logic              e_lock,
    output logic              e_gnt,
    output logic              e_valid,
    output logic [LINE_W-1:0] e_rdata,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [LINE_W-1:0] ram_data,
    input  logic [LINE_W-1:0] ram_q,
    // status
    output logic              locked
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FORCE  = 2'd2
    } state_t;

    // Owner tags carried alongside each RAM access until its data returns.
    localparam logic [1:0] C_TAG_NONE = 2'd0;
    localparam logic [1:0] C_TAG_R    = 2'd1;
    localparam logic [1:0] C_TAG_E    = 2'd2;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_starve_cnt;
    logic [3:0]          r_lock_cnt;
    logic                r_locked;
    logic                w_r_gnt;
    logic                w_e_gnt;
    logic [1:0]          w_tag_in;
    logic [1:0]          r_tag [RD_LATENCY];
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_wren;
    logic [LINE_W-1:0]   r_ram_data;
    logic                r_rvalid;
    logic                r_evalid;

    assign r_gnt    = w_r_gnt;
    assign e_gnt    = w_e_gnt;
    assign ram_addr = r_ram_addr;
    assign ram_wren = r_ram_wren;
    assign ram_data = r_ram_data;
    assign r_valid  = r_rvalid;
    assign e_valid  = r_evalid;
    assign r_data   = ram_q;
    assign e_rdata  = ram_q;
    assign locked   = r_locked;

    // Grant decode: at most one port wins, chosen by the current FSM state.
    always_comb begin
        w_r_gnt = 1'b0;
        w_e_gnt = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (r_req && e_req) begin
                    if (r_starve_cnt == STARVE_MAX) begin
                        w_e_gnt = 1'b1;
                    end else begin
                        w_r_gnt = 1'b1;
                    end
                end else begin
                    w_r_gnt = r_req;
                    w_e_gnt = e_req;
                end
            end
            ST_LOCKED: w_e_gnt = e_req;
            ST_FORCE:  w_r_gnt = r_req;
            default: begin
                w_r_gnt = 1'b0;
                w_e_gnt = 1'b0;
            end
        endcase
    end

    // Next-state decode; dropping e_lock always wins over the lock timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_e_gnt && e_lock) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!e_lock) begin
                    w_state_nxt = ST_ARB;
                end else if (r_lock_cnt == (LOCK_MAX - 4'd1)) begin
                    w_state_nxt = ST_FORCE;
                end
            end
            ST_FORCE:  w_state_nxt = e_lock ? ST_LOCKED : ST_ARB;
            default:   w_state_nxt = ST_ARB;
        endcase
    end

    // Read tag for the access being issued; writes never produce a valid.
    always_comb begin
        w_tag_in = C_TAG_NONE;
        if (w_r_gnt) begin
            w_tag_in = C_TAG_R;
        end else if (w_e_gnt && !e_we) begin
            w_tag_in = C_TAG_E;
        end
    end

    // FSM state, starvation/lock counters and the registered locked flag.
    // locked covers the FORCE slot too: the editor still owns the lock there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ARB;
            r_starve_cnt <= 4'd0;
            r_lock_cnt   <= 4'd0;
            r_locked     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt != ST_ARB);

            if (!e_req || w_e_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (w_r_gnt && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            case (r_state)
                ST_ARB: begin
                    if (w_state_nxt == ST_LOCKED) begin
                        r_lock_cnt <= 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (r_lock_cnt != 4'hF) begin
                        r_lock_cnt <= r_lock_cnt + 4'd1;
                    end
                end
                ST_FORCE: r_lock_cnt <= 4'd0;
                default:  r_lock_cnt <= 4'd0;
            endcase
        end
    end

    // RAM command register plus the owner-tag pipeline that times the valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr <= '0;
            r_ram_wren <= 1'b0;
            r_ram_data <= '0;
            r_rvalid   <= 1'b0;
            r_evalid   <= 1'b0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                r_tag[i] <= C_TAG_NONE;
            end
        end else begin
            if (w_r_gnt) begin
                r_ram_addr <= r_addr;
                r_ram_wren <= 1'b0;
            end else if (w_e_gnt) begin
                r_ram_addr <= e_addr;
                r_ram_wren <= e_we;
                r_ram_data <= e_wdata;
            end else begin
                r_ram_wren <= 1'b0;
            end

            r_tag[0] <= w_tag_in;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_rvalid <= (r_tag[RD_LATENCY-1] == C_TAG_R);
            r_evalid <= (r_tag[RD_LATENCY-1] == C_TAG_E);
        end
    end

endmodule

`default_nettype wire
